// File: rtl/p405s_icu_tag_bist_ctrl.sv
// March C- BIST controller for the ICU tag SRAM: sequences the six March elements
// over the BIST port and captures the first miscompare for diagnosis.
module p405s_icu_tag_bist_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 46
) (
  input  logic              cclk,
  input  logic              reset,
  input  logic              bist_start,
  input  logic [DATA_W-1:0] bist_rd_data,
  output logic              bist_mode,
  output logic              bist_ce_n,
  output logic              bist_we_n,
  output logic [ADDR_W-1:0] bist_addr,
  output logic [DATA_W-1:0] bist_wr_data,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_fail,
  output logic [ADDR_W-1:0] bist_fail_addr,
  output logic [2:0]        bist_fail_elem,
  output logic [DATA_W-1:0] bist_fail_syn
);

  localparam int unsigned ELEM_W = 3;
  localparam logic [ADDR_W-1:0] ADDR_MIN = '0;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_E0, S_E1, S_E2, S_E3, S_E4, S_E5, S_CHK, S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_phase;
  logic                r_cmp_vld;
  logic                r_cmp_exp_one;
  logic [ADDR_W-1:0]   r_cmp_addr;
  logic [ELEM_W-1:0]   r_cmp_elem;
  logic                r_fail;
  logic [ADDR_W-1:0]   r_fail_addr;
  logic [ELEM_W-1:0]   r_fail_elem;
  logic [DATA_W-1:0]   r_fail_syn;

  state_t              w_state_nxt;
  state_t              w_elem_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [ADDR_W-1:0]   w_start_addr;
  logic [ADDR_W-1:0]   w_addr_step;
  logic                w_phase_nxt;
  logic                w_rd;
  logic                w_wr;
  logic                w_clear;
  logic                w_up;
  logic                w_last;
  logic                w_exp_one;
  logic                w_wr_one;
  logic [ELEM_W-1:0]   w_elem;
  logic [DATA_W-1:0]   w_syn;
  logic                w_miscmp;

  // Element attributes, then sequencing; read/write decode depends on registered state only
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_phase_nxt  = r_phase;
    w_rd         = 1'b0;
    w_wr         = 1'b0;
    w_clear      = 1'b0;
    w_up         = 1'b1;
    w_exp_one    = 1'b0;
    w_wr_one     = 1'b0;
    w_elem       = '0;
    w_elem_nxt   = S_IDLE;
    w_start_addr = ADDR_MIN;

    case (r_state)
      S_E1: begin w_wr_one = 1'b1; w_elem = ELEM_W'(1); w_elem_nxt = S_E2; end
      S_E2: begin w_exp_one = 1'b1; w_elem = ELEM_W'(2); w_elem_nxt = S_E3; w_start_addr = ADDR_MAX; end
      S_E3: begin
        w_up = 1'b0; w_wr_one = 1'b1; w_elem = ELEM_W'(3); w_elem_nxt = S_E4; w_start_addr = ADDR_MAX;
      end
      S_E4: begin w_up = 1'b0; w_exp_one = 1'b1; w_elem = ELEM_W'(4); w_elem_nxt = S_E5; end
      S_E5: w_elem = ELEM_W'(5);
      default: ;
    endcase

    w_last      = w_up ? (r_addr == ADDR_MAX) : (r_addr == ADDR_MIN);
    w_addr_step = w_up ? (r_addr + ADDR_ONE) : (r_addr - ADDR_ONE);

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bist_start) begin
          w_state_nxt = S_E0;
          w_addr_nxt  = ADDR_MIN;
          w_phase_nxt = 1'b0;
          w_clear     = 1'b1;
        end
      end
      S_E0: begin
        w_wr = 1'b1;
        if (w_last) begin
          w_state_nxt = S_E1;
          w_addr_nxt  = ADDR_MIN;
        end else begin
          w_addr_nxt = w_addr_step;
        end
      end
      S_E1, S_E2, S_E3, S_E4: begin
        if (!r_phase) begin
          w_rd        = 1'b1;
          w_phase_nxt = 1'b1;
        end else begin
          w_wr        = 1'b1;
          w_phase_nxt = 1'b0;
          if (w_last) begin
            w_state_nxt = w_elem_nxt;
            w_addr_nxt  = w_start_addr;
          end else begin
            w_addr_nxt = w_addr_step;
          end
        end
      end
      S_E5: begin
        w_rd = 1'b1;
        if (w_last) begin
          w_state_nxt = S_CHK;
          w_addr_nxt  = ADDR_MIN;
        end else begin
          w_addr_nxt = w_addr_step;
        end
      end
      S_CHK:   w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_syn    = bist_rd_data ^ {DATA_W{r_cmp_exp_one}};
  assign w_miscmp = r_cmp_vld && (w_syn != '0);

  // State, compare pipeline and sticky first-failure capture
  always_ff @(posedge cclk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_phase       <= 1'b0;
      r_cmp_vld     <= 1'b0;
      r_cmp_exp_one <= 1'b0;
      r_cmp_addr    <= '0;
      r_cmp_elem    <= '0;
      r_fail        <= 1'b0;
      r_fail_addr   <= '0;
      r_fail_elem   <= '0;
      r_fail_syn    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_addr        <= w_addr_nxt;
      r_phase       <= w_phase_nxt;
      r_cmp_vld     <= w_rd;
      r_cmp_exp_one <= w_exp_one;
      r_cmp_addr    <= r_addr;
      r_cmp_elem    <= w_elem;
      if (w_clear) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_elem <= '0;
        r_fail_syn  <= '0;
      end else if (w_miscmp && !r_fail) begin
        r_fail      <= 1'b1;
        r_fail_addr <= r_cmp_addr;
        r_fail_elem <= r_cmp_elem;
        r_fail_syn  <= w_syn;
      end
    end
  end

  assign bist_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bist_mode      = bist_busy;
  assign bist_done      = (r_state == S_DONE);
  assign bist_ce_n      = !(w_rd || w_wr);
  assign bist_we_n      = !w_wr;
  assign bist_addr      = r_addr;
  assign bist_wr_data   = {DATA_W{w_wr && w_wr_one}};
  assign bist_fail      = r_fail;
  assign bist_fail_addr = r_fail_addr;
  assign bist_fail_elem = r_fail_elem;
  assign bist_fail_syn  = r_fail_syn;

endmodule

// File: tb/tb_p405s_icu_tag_bist_ctrl.sv
// Directed bench for the tag SRAM March C- BIST controller with a behavioural SRAM
// that can inject stuck-at bits on one address or corrupt the final read.
module tb_p405s_icu_tag_bist_ctrl;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 46;

  logic              cclk;
  logic              reset;
  logic              bist_start;
  logic [DATA_W-1:0] bist_rd_data;
  logic              bist_mode;
  logic              bist_ce_n;
  logic              bist_we_n;
  logic [ADDR_W-1:0] bist_addr;
  logic [DATA_W-1:0] bist_wr_data;
  logic              bist_busy;
  logic              bist_done;
  logic              bist_fail;
  logic [ADDR_W-1:0] bist_fail_addr;
  logic [2:0]        bist_fail_elem;
  logic [DATA_W-1:0] bist_fail_syn;

  int n_tests = 0;
  int n_fail  = 0;

  // SRAM model and fault injection controls
  logic [DATA_W-1:0] mem [256];
  logic [ADDR_W-1:0] fault_addr;
  logic [DATA_W-1:0] sa0_mask;
  logic [DATA_W-1:0] sa1_mask;
  bit                flip_last;
  int                wr_cnt;
  int                rd_cnt;

  // Snapshots taken during a run
  logic              s1_ce_n, s1_we_n, s1_busy;
  logic [ADDR_W-1:0] s1_addr;
  logic [ADDR_W-1:0] s_e3_addr;
  logic              s_e3_we_n;
  logic              s_chk_ce_n, s_chk_busy, s_chk_fail;

  p405s_icu_tag_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .cclk(cclk), .reset(reset), .bist_start(bist_start), .bist_rd_data(bist_rd_data),
    .bist_mode(bist_mode), .bist_ce_n(bist_ce_n), .bist_we_n(bist_we_n),
    .bist_addr(bist_addr), .bist_wr_data(bist_wr_data), .bist_busy(bist_busy),
    .bist_done(bist_done), .bist_fail(bist_fail), .bist_fail_addr(bist_fail_addr),
    .bist_fail_elem(bist_fail_elem), .bist_fail_syn(bist_fail_syn)
  );

  initial begin
    cclk = 1'b0;
    forever #5 cclk = ~cclk;
  end

  always @(posedge cclk) begin
    logic [DATA_W-1:0] rd;
    if (!bist_ce_n) begin
      if (!bist_we_n) begin
        mem[bist_addr] <= bist_wr_data;
        wr_cnt = wr_cnt + 1;
      end else begin
        rd = mem[bist_addr];
        if (bist_addr == fault_addr) rd = (rd & ~sa0_mask) | sa1_mask;
        if (flip_last && rd_cnt == 1279) rd = rd ^ DATA_W'(46'h20);
        bist_rd_data <= rd;
        rd_cnt = rd_cnt + 1;
      end
    end
  end

  task automatic set_fault(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] m0,
                           input logic [DATA_W-1:0] m1, input bit fl);
    fault_addr = a; sa0_mask = m0; sa1_mask = m1; flip_last = fl;
  endtask

  // Starts a run from the current cycle (called at posedge+1) and returns the done cycle
  task automatic run_bist(input bit hold, output int done_cyc);
    wr_cnt = 0; rd_cnt = 0; done_cyc = -1;
    bist_start = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge cclk); #1;
      if (!hold) bist_start = 1'b0;
      if (n == 1) begin s1_ce_n = bist_ce_n; s1_we_n = bist_we_n; s1_busy = bist_busy; s1_addr = bist_addr; end
      if (n == 1281) begin s_e3_addr = bist_addr; s_e3_we_n = bist_we_n; end
      if (n == 2561) begin s_chk_ce_n = bist_ce_n; s_chk_busy = bist_busy; s_chk_fail = bist_fail; end
      if (bist_done) begin done_cyc = n; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; bist_start = 1'b0;
    repeat (2) @(posedge cclk); #1;
    n_tests++; if ({bist_mode, bist_ce_n, bist_we_n, bist_busy, bist_done, bist_fail} !== 6'b011000) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=011000", {bist_mode, bist_ce_n, bist_we_n, bist_busy, bist_done, bist_fail}); end
    n_tests++; if (bist_addr !== 8'h00 || bist_wr_data !== 46'h0) begin
      n_fail++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", bist_addr, bist_wr_data); end
    n_tests++; if (bist_fail_addr !== 8'h00 || bist_fail_elem !== 3'd0 || bist_fail_syn !== 46'h0) begin
      n_fail++; $display("FAIL reset_diag got=%h/%0d/%h exp=0/0/0", bist_fail_addr, bist_fail_elem, bist_fail_syn); end
    reset = 1'b0;
    repeat (3) @(posedge cclk); #1;
    n_tests++; if (bist_ce_n !== 1'b1 || bist_busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_start got ce_n=%b busy=%b exp 1/0", bist_ce_n, bist_busy); end
  endtask

  task automatic test_clean;
    int dc;
    set_fault(8'h00, '0, '0, 1'b0);
    run_bist(1'b0, dc);
    n_tests++; if (dc != 2562) begin n_fail++; $display("FAIL clean_done_cycle got=%0d exp=2562", dc); end
    n_tests++; if (bist_fail !== 1'b0) begin n_fail++; $display("FAIL clean_fail got=%b exp=0", bist_fail); end
    n_tests++; if (wr_cnt != 1280 || rd_cnt != 1280) begin
      n_fail++; $display("FAIL clean_access_count got wr=%0d rd=%0d exp 1280/1280", wr_cnt, rd_cnt); end
    n_tests++; if ({s1_ce_n, s1_we_n, s1_busy} !== 3'b001 || s1_addr !== 8'h00) begin
      n_fail++; $display("FAIL e0_first_write got ce/we/busy=%b addr=%h exp 001/00", {s1_ce_n, s1_we_n, s1_busy}, s1_addr); end
    n_tests++; if (s_e3_addr !== 8'hFF || s_e3_we_n !== 1'b1) begin
      n_fail++; $display("FAIL e3_start got addr=%h we_n=%b exp FF/1", s_e3_addr, s_e3_we_n); end
    n_tests++; if (s_chk_ce_n !== 1'b1 || s_chk_busy !== 1'b1) begin
      n_fail++; $display("FAIL chk_no_access got ce_n=%b busy=%b exp 1/1", s_chk_ce_n, s_chk_busy); end
    n_tests++; if (bist_mode !== 1'b0 || bist_ce_n !== 1'b1 || bist_busy !== 1'b0) begin
      n_fail++; $display("FAIL done_idle_port got mode=%b ce_n=%b busy=%b exp 0/1/0", bist_mode, bist_ce_n, bist_busy); end
  endtask

  task automatic test_stuck1_bit17;
    int dc;
    set_fault(8'h3C, '0, 46'h20000, 1'b0);
    run_bist(1'b0, dc);
    n_tests++; if (dc != 2562) begin n_fail++; $display("FAIL sa1_done_cycle got=%0d exp=2562", dc); end
    n_tests++; if (bist_fail !== 1'b1 || bist_fail_addr !== 8'h3C || bist_fail_elem !== 3'd1) begin
      n_fail++; $display("FAIL sa1_diag got fail=%b addr=%h elem=%0d exp 1/3C/1", bist_fail, bist_fail_addr, bist_fail_elem); end
    n_tests++; if (bist_fail_syn !== 46'h20000) begin
      n_fail++; $display("FAIL sa1_syn got=%h exp=%h", bist_fail_syn, 46'h20000); end
  endtask

  task automatic test_stuck0_top;
    int dc;
    set_fault(8'hFF, 46'h1, '0, 1'b0);
    run_bist(1'b0, dc);
    n_tests++; if (dc != 2562) begin n_fail++; $display("FAIL sa0_done_cycle got=%0d exp=2562", dc); end
    n_tests++; if (bist_fail !== 1'b1 || bist_fail_addr !== 8'hFF || bist_fail_elem !== 3'd2) begin
      n_fail++; $display("FAIL sa0_first_fail got fail=%b addr=%h elem=%0d exp 1/FF/2", bist_fail, bist_fail_addr, bist_fail_elem); end
    n_tests++; if (bist_fail_syn !== 46'h1) begin n_fail++; $display("FAIL sa0_syn got=%h exp=1", bist_fail_syn); end
  endtask

  task automatic test_reset_midrun;
    int dc;
    bit fail_before;
    set_fault(8'h3C, '0, 46'h20000, 1'b0);
    bist_start = 1'b1;
    fail_before = 1'b0;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge cclk); #1;
      bist_start = 1'b0;
      if (n == 1000) fail_before = bist_fail;
    end
    reset = 1'b1;
    @(posedge cclk); #1;
    n_tests++; if (fail_before !== 1'b1) begin n_fail++; $display("FAIL midrun_fail_before got=%b exp=1", fail_before); end
    n_tests++; if ({bist_mode, bist_ce_n, bist_we_n, bist_busy, bist_done, bist_fail} !== 6'b011000 ||
                   bist_addr !== 8'h00 || bist_wr_data !== 46'h0) begin
      n_fail++; $display("FAIL midrun_reset_ctrl got=%b addr=%h exp=011000/00", {bist_mode, bist_ce_n, bist_we_n, bist_busy, bist_done, bist_fail}, bist_addr); end
    n_tests++; if (bist_fail_addr !== 8'h00 || bist_fail_elem !== 3'd0 || bist_fail_syn !== 46'h0) begin
      n_fail++; $display("FAIL midrun_reset_diag got=%h/%0d/%h exp=0/0/0", bist_fail_addr, bist_fail_elem, bist_fail_syn); end
    reset = 1'b0;
    repeat (3) @(posedge cclk); #1;
    n_tests++; if (bist_ce_n !== 1'b1 || bist_fail !== 1'b0) begin
      n_fail++; $display("FAIL midrun_post_reset got ce_n=%b fail=%b exp 1/0", bist_ce_n, bist_fail); end
    set_fault(8'h00, '0, '0, 1'b0);
    run_bist(1'b0, dc);
    n_tests++; if (dc != 2562 || bist_fail !== 1'b0) begin
      n_fail++; $display("FAIL midrun_rerun got cycle=%0d fail=%b exp 2562/0", dc, bist_fail); end
  endtask

  task automatic test_hold_start;
    int dc;
    set_fault(8'h3C, '0, 46'h20000, 1'b0);
    run_bist(1'b1, dc);
    n_tests++; if (dc != 2562 || bist_fail !== 1'b1) begin
      n_fail++; $display("FAIL hold_done got cycle=%0d fail=%b exp 2562/1", dc, bist_fail); end
    @(posedge cclk); #1;
    n_tests++; if ({bist_busy, bist_done, bist_fail, bist_ce_n, bist_we_n} !== 5'b10000 || bist_addr !== 8'h00) begin
      n_fail++; $display("FAIL hold_restart got busy/done/fail/ce_n/we_n=%b addr=%h exp 10000/00", {bist_busy, bist_done, bist_fail, bist_ce_n, bist_we_n}, bist_addr); end
    n_tests++; if (bist_fail_elem !== 3'd0 || bist_fail_syn !== 46'h0) begin
      n_fail++; $display("FAIL hold_diag_clear got elem=%0d syn=%h exp 0/0", bist_fail_elem, bist_fail_syn); end
    bist_start = 1'b0;
    reset = 1'b1;
    @(posedge cclk); #1;
    reset = 1'b0;
    @(posedge cclk); #1;
  endtask

  task automatic test_last_read;
    int dc;
    set_fault(8'h00, '0, '0, 1'b1);
    run_bist(1'b0, dc);
    n_tests++; if (s_chk_fail !== 1'b0) begin n_fail++; $display("FAIL last_chk_fail got=%b exp=0", s_chk_fail); end
    n_tests++; if (dc != 2562 || bist_fail !== 1'b1) begin
      n_fail++; $display("FAIL last_done got cycle=%0d fail=%b exp 2562/1", dc, bist_fail); end
    n_tests++; if (bist_fail_elem !== 3'd5 || bist_fail_addr !== 8'hFF || bist_fail_syn !== 46'h20) begin
      n_fail++; $display("FAIL last_diag got elem=%0d addr=%h syn=%h exp 5/FF/20", bist_fail_elem, bist_fail_addr, bist_fail_syn); end
    set_fault(8'h00, '0, '0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    wr_cnt = 0; rd_cnt = 0;
    set_fault(8'h00, '0, '0, 1'b0);
    reset = 1'b1; bist_start = 1'b0;
    test_reset;
    test_clean;
    test_stuck1_bit17;
    test_stuck0_top;
    test_reset_midrun;
    test_hold_start;
    test_last_read;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
